// File: rtl/card_shoe.sv
// 52-slot card shoe: dealt-flag bitmap with forward wrap-around probing from a random start slot.
// One probe per cycle while searching; shuffle restores the full deck from any state.
module card_shoe #(
  parameter int unsigned DECK_SIZE = 52,
  parameter int unsigned RANKS     = 13,
  parameter int unsigned CARD_W    = 4,
  parameter int unsigned IDX_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [IDX_W-1:0]  random,
  input  logic              shuffle,
  output logic              ready,
  output logic              card_valid,
  output logic [CARD_W-1:0] card,
  output logic [IDX_W-1:0]  card_idx,
  output logic [IDX_W-1:0]  cards_left,
  output logic              empty
);

  localparam logic [IDX_W-1:0] DECK_N  = IDX_W'(DECK_SIZE);
  localparam logic [IDX_W-1:0] LAST_IX = IDX_W'(DECK_SIZE - 1);
  localparam logic [IDX_W-1:0] RANK_1  = IDX_W'(RANKS);
  localparam logic [IDX_W-1:0] RANK_2  = IDX_W'(2 * RANKS);
  localparam logic [IDX_W-1:0] RANK_3  = IDX_W'(3 * RANKS);

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     probe_q, probe_d;
  logic [DECK_SIZE-1:0] dealt_q, dealt_d;
  logic [IDX_W-1:0]     left_d;
  logic [CARD_W-1:0]    card_d;
  logic [IDX_W-1:0]     card_idx_d;
  logic                 valid_d;
  logic [IDX_W-1:0]     start_idx;
  logic [IDX_W-1:0]     probe_rank;
  logic                 accept;
  logic                 hit;

  assign accept = req && ready && !shuffle;
  assign hit    = (state_q == SEARCH) && !dealt_q[probe_q];

  // Seed folded into 0..DECK_SIZE-1 and probe slot reduced to its rank without a divider.
  always_comb begin
    start_idx = (random >= DECK_N) ? random - DECK_N : random;
    if (probe_q >= RANK_3)      probe_rank = probe_q - RANK_3;
    else if (probe_q >= RANK_2) probe_rank = probe_q - RANK_2;
    else if (probe_q >= RANK_1) probe_rank = probe_q - RANK_1;
    else                        probe_rank = probe_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (shuffle) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = SEARCH;
        SEARCH:  if (hit)    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next values; shuffle wins over any accept or hit in the same cycle.
  always_comb begin
    probe_d    = probe_q;
    dealt_d    = dealt_q;
    left_d     = cards_left;
    card_d     = card;
    card_idx_d = card_idx;
    valid_d    = 1'b0;
    if (shuffle) begin
      dealt_d = '0;
      left_d  = DECK_N;
    end else if (state_q == IDLE) begin
      if (accept) probe_d = start_idx;
    end else if (hit) begin
      dealt_d[probe_q] = 1'b1;
      card_d           = CARD_W'(probe_rank) + CARD_W'(1);
      card_idx_d       = probe_q;
      valid_d          = 1'b1;
      if (cards_left != '0) left_d = cards_left - IDX_W'(1);
    end else begin
      probe_d = (probe_q == LAST_IX) ? '0 : probe_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      probe_q    <= '0;
      dealt_q    <= '0;
      cards_left <= DECK_N;
      card       <= '0;
      card_idx   <= '0;
      card_valid <= 1'b0;
      ready      <= 1'b1;
      empty      <= 1'b0;
    end else begin
      probe_q    <= probe_d;
      dealt_q    <= dealt_d;
      cards_left <= left_d;
      card       <= card_d;
      card_idx   <= card_idx_d;
      card_valid <= valid_d;
      ready      <= (state_d == IDLE) && (left_d != '0);
      empty      <= (left_d == '0);
    end
  end

endmodule

// File: tb/tb_card_shoe.sv
// Self-checking bench for card_shoe: directed corner cases plus randomized draws against a deck model.
module tb_card_shoe;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req = 1'b0;
  logic [5:0] random = '0;
  logic       shuffle = 1'b0;
  logic       ready, card_valid, empty;
  logic [3:0] card;
  logic [5:0] card_idx, cards_left;

  int n_cmp = 0;
  int n_bad = 0;

  bit model_dealt [52];
  int model_left;
  int last_card;
  int last_idx;
  int rank_cnt [13];

  card_shoe dut (
    .clk(clk), .reset(reset), .req(req), .random(random), .shuffle(shuffle),
    .ready(ready), .card_valid(card_valid), .card(card), .card_idx(card_idx),
    .cards_left(cards_left), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required finish)", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_full;
    for (int i = 0; i < 52; i++) model_dealt[i] = 1'b0;
    model_left = 52;
  endtask

  // One draw: wait for ready, accept with seed, expect the first free slot at or after seed mod 52.
  task automatic draw(input int seed, input bit check_drop, output int got_idx);
    int start, exp_idx, p, cnt;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 100) begin tick; cnt++; end
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL draw_ready: ready=%b required 1", ready);
    end
    start = seed % 52;
    exp_idx = -1;
    p = 0;
    for (int k = 0; k < 52; k++) begin
      if (exp_idx < 0 && !model_dealt[(start + k) % 52]) begin
        exp_idx = (start + k) % 52;
        p = k + 1;
      end
    end
    req = 1'b1;
    random = 6'(seed);
    tick;
    req = 1'b0;
    cnt = 0;
    while (card_valid !== 1'b1 && cnt < 60) begin tick; cnt++; end
    model_dealt[exp_idx] = 1'b1;
    model_left--;
    last_idx = exp_idx;
    last_card = exp_idx % 13 + 1;
    got_idx = int'(card_idx);
    n_cmp++;
    if (cnt != p) begin
      n_bad++;
      $display("FAIL draw_latency seed=%0d: %0d probe cycles, required %0d", seed, cnt, p);
    end
    n_cmp++;
    if (card_idx !== 6'(exp_idx)) begin
      n_bad++;
      $display("FAIL draw_idx seed=%0d: card_idx=%0d required %0d", seed, card_idx, exp_idx);
    end
    n_cmp++;
    if (card !== 4'(last_card)) begin
      n_bad++;
      $display("FAIL draw_card seed=%0d: card=%0d required %0d", seed, card, last_card);
    end
    n_cmp++;
    if (cards_left !== 6'(model_left)) begin
      n_bad++;
      $display("FAIL draw_left seed=%0d: cards_left=%0d required %0d", seed, cards_left, model_left);
    end
    if (check_drop) begin
      tick;
      n_cmp++;
      if (card_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL valid_pulse: card_valid=%b one cycle after delivery, required 0", card_valid);
      end
    end
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick;
      if (card_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL %s: card_valid seen high, required no delivery", name);
    end
  endtask

  task automatic do_shuffle;
    shuffle = 1'b1;
    tick;
    shuffle = 1'b0;
    model_full();
    n_cmp++;
    if (cards_left !== 6'd52 || ready !== 1'b1) begin
      n_bad++;
      $display("FAIL shuffle: cards_left=%0d ready=%b required 52/1", cards_left, ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #23;
    n_cmp++;
    if (card_valid !== 1'b0 || cards_left !== 6'd52 || empty !== 1'b0 || card !== 4'd0 || card_idx !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_values: valid=%b left=%0d empty=%b card=%0d idx=%0d required 0/52/0/0/0",
               card_valid, cards_left, empty, card, card_idx);
    end
    @(negedge clk);
    reset = 1'b1;
    tick;
    model_full();
    last_card = 0;
    last_idx = 0;
    n_cmp++;
    if (ready !== 1'b1 || empty !== 1'b0 || cards_left !== 6'd52) begin
      n_bad++;
      $display("FAIL reset_release: ready=%b empty=%b left=%0d required 1/0/52", ready, empty, cards_left);
    end
  endtask

  task automatic test_directed;
    int got;
    draw(0, 1'b1, got);
    n_cmp++;
    if (got != 0 || card !== 4'd1) begin
      n_bad++; $display("FAIL t2_first: idx=%0d card=%0d required 0/1", got, card);
    end
    draw(0, 1'b1, got);
    n_cmp++;
    if (got != 1 || card !== 4'd2 || cards_left !== 6'd50) begin
      n_bad++; $display("FAIL t3_second: idx=%0d card=%0d left=%0d required 1/2/50", got, card, cards_left);
    end
    draw(63, 1'b1, got);
    n_cmp++;
    if (got != 11 || card !== 4'd12) begin
      n_bad++; $display("FAIL t4_seed63: idx=%0d card=%0d required 11/12", got, card);
    end
    draw(51, 1'b1, got);
    n_cmp++;
    if (got != 51 || card !== 4'd13) begin
      n_bad++; $display("FAIL t4_seed51: idx=%0d card=%0d required 51/13", got, card);
    end
    draw(51, 1'b1, got);
    n_cmp++;
    if (got != 2 || card !== 4'd3) begin
      n_bad++; $display("FAIL t4_wrap: idx=%0d card=%0d required 2/3", got, card);
    end
  endtask

  task automatic test_back_to_back;
    int got;
    for (int i = 0; i < 6; i++) begin
      draw(int'($urandom_range(0, 63)), 1'b0, got);
      n_cmp++;
      if (ready !== 1'b1 || card_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_ready: ready=%b card_valid=%b in delivery cycle, required 1/1", ready, card_valid);
      end
    end
    draw(int'($urandom_range(0, 63)), 1'b1, got);
  endtask

  task automatic test_random;
    int got, gap;
    for (int i = 0; i < 30; i++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) tick;
      draw(int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), got);
    end
  endtask

  task automatic test_exhaust;
    int got;
    do_shuffle();
    for (int r = 0; r < 13; r++) rank_cnt[r] = 0;
    for (int i = 0; i < 52; i++) begin
      draw(int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), got);
      rank_cnt[int'(card) % 13]++;
    end
    tick;
    for (int r = 0; r < 13; r++) begin
      n_cmp++;
      if (rank_cnt[r] != 4) begin
        n_bad++; $display("FAIL rank_count id=%0d: %0d cards, required 4", (r == 0) ? 13 : r, rank_cnt[r]);
      end
    end
    n_cmp++;
    if (empty !== 1'b1 || ready !== 1'b0 || cards_left !== 6'd0) begin
      n_bad++; $display("FAIL empty_state: empty=%b ready=%b left=%0d required 1/0/0", empty, ready, cards_left);
    end
    req = 1'b1;
    random = 6'($urandom_range(0, 63));
    expect_quiet("empty_req", 8);
    req = 1'b0;
    do_shuffle();
  endtask

  task automatic test_abort;
    int got;
    for (int i = 0; i < 30; i++) draw(int'($urandom_range(0, 63)), 1'b1, got);
    req = 1'b1;
    random = 6'($urandom_range(0, 63));
    tick;
    req = 1'b0;
    shuffle = 1'b1;
    tick;
    shuffle = 1'b0;
    model_full();
    n_cmp++;
    if (card_valid !== 1'b0 || cards_left !== 6'd52 || ready !== 1'b1) begin
      n_bad++; $display("FAIL shuffle_abort: valid=%b left=%0d ready=%b required 0/52/1", card_valid, cards_left, ready);
    end
    n_cmp++;
    if (card !== 4'(last_card) || card_idx !== 6'(last_idx)) begin
      n_bad++; $display("FAIL shuffle_hold: card=%0d idx=%0d required %0d/%0d", card, card_idx, last_card, last_idx);
    end
    expect_quiet("shuffle_abort_quiet", 5);

    for (int i = 0; i < 10; i++) draw(int'($urandom_range(0, 63)), 1'b1, got);
    req = 1'b1;
    random = 6'($urandom_range(0, 63));
    tick;
    req = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_full();
    last_card = 0;
    last_idx = 0;
    n_cmp++;
    if (card_valid !== 1'b0 || cards_left !== 6'd52 || card !== 4'd0) begin
      n_bad++; $display("FAIL reset_abort: valid=%b left=%0d card=%0d required 0/52/0", card_valid, cards_left, card);
    end
    #1;
    reset = 1'b1;
    expect_quiet("reset_abort_quiet", 5);

    for (int i = 0; i < 5; i++) draw(int'($urandom_range(0, 63)), 1'b1, got);
    req = 1'b1;
    shuffle = 1'b1;
    random = 6'($urandom_range(0, 63));
    tick;
    req = 1'b0;
    shuffle = 1'b0;
    model_full();
    n_cmp++;
    if (ready !== 1'b1 || cards_left !== 6'd52) begin
      n_bad++; $display("FAIL req_with_shuffle: ready=%b left=%0d required 1/52", ready, cards_left);
    end
    expect_quiet("req_with_shuffle_quiet", 5);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_exhaust();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
